reg_file_mp: RTL

Parametrised multi-port register file, the successor to the 4x8 single-port register file.
- Two combinational read ports and one clocked write port.
- Synchronous active-low reset.
- Optional hard-wired zero register.
- Sequenced "clear sweep" engine that zeroes the array one entry per cycle under handshake.
- Sits between the datapath ALU/operand muxes and the multicycle controller.

---
 rtl/reg_file_mp.sv | 98 +++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, one write port, and a clear-sweep engine.
// Define RFILE_WR_BYPASS_EN to forward same-cycle accepted writes onto the read ports.
module reg_file_mp #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                ZERO_REG  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam bit                ZR       = (ZERO_REG != 0);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam int                NPORTS   = 2;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [ADDR_W:0]                 r_idx;
    logic [DEPTH-1:0][DATA_W-1:0]    r_mem;
    logic                            r_wr_drop;
    logic                            w_busy;
    logic                            w_zr_hit;
    logic                            w_wr_ok;
    logic [NPORTS-1:0][ADDR_W-1:0]   w_raddr;
    logic [NPORTS-1:0][DATA_W-1:0]   w_rdata;

    assign w_busy   = (r_state == S_SWEEP);
    assign w_zr_hit = ZR && (waddr == '0);
    assign w_wr_ok  = we && !w_busy && !w_zr_hit;

    assign busy     = w_busy;
    assign clr_done = (r_state == S_DONE);
    assign wr_drop  = r_wr_drop;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // clr_req is only honoured from IDLE; DONE always returns to IDLE first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx     <= '0;
            r_wr_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
        end else begin
            r_wr_drop <= we && (w_busy || w_zr_hit);
            if (w_busy) begin
                r_mem[r_idx[ADDR_W-1:0]] <= RESET_VAL;
                r_idx <= r_idx + (ADDR_W+1)'(1);
            end else begin
                if (r_state == S_IDLE && clr_req) r_idx <= '0;
                if (w_wr_ok) r_mem[waddr] <= wdata;
            end
        end
    end

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        logic w_byp;
`ifdef RFILE_WR_BYPASS_EN
        assign w_byp = w_wr_ok && (waddr == w_raddr[p]);
`else
        assign w_byp = 1'b0;
`endif
        assign w_rdata[p] = (ZR && w_raddr[p] == '0) ? '0 :
                            w_byp                   ? wdata :
                                                      r_mem[w_raddr[p]];
    end

    assign rdata_a = w_rdata[0];
    assign rdata_b = w_rdata[1];
endmodule
